lfsr_addr_scrambler: RTL and testbench

- Parametrised, key-programmable LFSR address scrambler. Successor to the fixed 12-bit, 4-tap scrambler.
- Accepts one address per transaction through a valid/ready handshake and runs ROUNDS LFSR shifts with key-selected feedback taps.
- Returns the scrambled address through a second valid/ready handshake.
- Sits between the address generator and the interleaved memory / block-RAM address port.

---
 rtl/lfsr_addr_scrambler.sv | 143 ++++++++++++++
 tb/tb_lfsr_addr_scrambler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_addr_scrambler.sv
// Key-programmable LFSR address scrambler with valid/ready handshakes on input and output.
// Optional macro SCRAMBLER_DESCRAMBLE_EN adds a per-transaction inverse mode and a key_err flag.
module lfsr_addr_scrambler #(
  parameter int ADDR_W   = 12,
  parameter int NUM_TAPS = 4,
  parameter int IDX_W    = 4,
  parameter int ROUNDS   = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [NUM_TAPS*IDX_W-1:0] key,
`ifdef SCRAMBLER_DESCRAMBLE_EN
  input  logic                      mode,
  output logic                      key_err,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      busy
);

  localparam int              CNT_W = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [ADDR_W-1:0]         lfsr;
  logic [ADDR_W-1:0]         lfsr_step;
  logic [NUM_TAPS*IDX_W-1:0] taps;
  logic [CNT_W-1:0]          count;
  logic                      fb;
`ifdef SCRAMBLER_DESCRAMBLE_EN
  logic                      mode_r;
  logic                      inv_fb;
`endif

  // Parity of the number of taps in t that select bit position pos; pairs cancel, out-of-range taps never match.
  function automatic logic tap_parity(input logic [NUM_TAPS*IDX_W-1:0] t, input int pos);
    logic p;
    p = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (t[i*IDX_W +: IDX_W] == IDX_W'(pos)) begin
        p = ~p;
      end
    end
    return p;
  endfunction

  // One LFSR step (forward, or inverse when descrambling).
  always_comb begin
    fb = 1'b0;
    for (int j = 0; j < ADDR_W; j++) begin
      fb = fb ^ (tap_parity(taps, j) & lfsr[j]);
    end
`ifdef SCRAMBLER_DESCRAMBLE_EN
    inv_fb = lfsr[0];
    for (int j = 0; j < ADDR_W - 1; j++) begin
      inv_fb = inv_fb ^ (tap_parity(taps, j) & lfsr[j+1]);
    end
    if (mode_r) begin
      lfsr_step = {inv_fb, lfsr[ADDR_W-1:1]};
    end else begin
      lfsr_step = {lfsr[ADDR_W-2:0], fb};
    end
`else
    lfsr_step = {lfsr[ADDR_W-2:0], fb};
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = SHIFT;
        else          state_nxt = IDLE;
      end
      SHIFT: begin
        if (count == LAST) state_nxt = DONE;
        else               state_nxt = SHIFT;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
        else           state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: capture on accept, shift while in SHIFT, publish the final shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr     <= '0;
      taps     <= '0;
      count    <= '0;
      out_addr <= '0;
`ifdef SCRAMBLER_DESCRAMBLE_EN
      mode_r   <= 1'b0;
      key_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lfsr    <= in_addr;
            taps    <= key;
            count   <= '0;
`ifdef SCRAMBLER_DESCRAMBLE_EN
            mode_r  <= mode;
            key_err <= ~tap_parity(key, ADDR_W - 1);
`endif
          end
        end
        SHIFT: begin
          lfsr  <= lfsr_step;
          count <= count + 1'b1;
          if (count == LAST) out_addr <= lfsr_step;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_lfsr_addr_scrambler.sv
// Directed bench: a ROUNDS=1 instance (a_*) and a default ROUNDS=12 instance (b_*).
module tb_lfsr_addr_scrambler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [11:0] a_in_addr, a_out_addr;
  logic [15:0] a_key;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [11:0] b_in_addr, b_out_addr;
  logic [15:0] b_key;
`ifdef SCRAMBLER_DESCRAMBLE_EN
  logic        a_mode, a_key_err, b_mode, b_key_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  lfsr_addr_scrambler #(.ROUNDS(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_addr(a_in_addr), .key(a_key),
`ifdef SCRAMBLER_DESCRAMBLE_EN
    .mode(a_mode), .key_err(a_key_err),
`endif
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr), .busy(a_busy)
  );

  lfsr_addr_scrambler u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_addr(b_in_addr), .key(b_key),
`ifdef SCRAMBLER_DESCRAMBLE_EN
    .mode(b_mode), .key_err(b_key_err),
`endif
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference scrambler: shift left, feedback = parity of selected in-range bits.
  function automatic logic [11:0] model(input logic [11:0] seed, input logic [15:0] k, input int rounds);
    logic [11:0] s;
    int ones;
    int t;
    s = seed;
    for (int r = 0; r < rounds; r++) begin
      ones = 0;
      for (int i = 0; i < 4; i++) begin
        t = int'(k >> (4 * i)) & 15;
        if (t < 12) ones += int'((s >> t) & 12'd1);
      end
      s = {s[10:0], ones[0]};
    end
    return s;
  endfunction

  // Called at a negedge with the selected instance idle.
  task automatic xact(input bit sel, input logic [11:0] addr, input logic [15:0] k,
                      input logic [11:0] exp, input int rounds, input string tag,
                      output logic [11:0] res);
    int lat;
    if (sel) begin b_in_addr = addr; b_key = k; b_in_valid = 1'b1; end
    else     begin a_in_addr = addr; a_key = k; a_in_valid = 1'b1; end
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    check({tag, "_busy"}, sel ? b_busy : a_busy, 32'd1);
    check({tag, "_inrdy"}, sel ? b_in_ready : a_in_ready, 32'd0);
    lat = 0;
    while (!(sel ? b_out_valid : a_out_valid) && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, rounds);
    res = sel ? b_out_addr : a_out_addr;
    check({tag, "_addr"}, res, exp);
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    check({tag, "_drop"}, sel ? b_out_valid : a_out_valid, 32'd0);
  endtask

  initial begin
    logic [11:0] r_addr, exp, res;
    logic [15:0] r_key;
    int          lat;
    logic        saw;

    reset = 1'b0;
    a_in_valid = 1'b1; a_in_addr = 12'h001; a_key = 16'hB000; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_addr = 12'h000; b_key = 16'h0000; b_out_ready = 1'b0;
`ifdef SCRAMBLER_DESCRAMBLE_EN
    a_mode = 1'b0; b_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ovalid", a_out_valid, 32'd0);
    check("rst_oaddr", a_out_addr, 32'd0);
    check("rst_busy", a_busy, 32'd0);
    check("rst_b_ovalid", b_out_valid, 32'd0);
    reset = 1'b1;
    #1;
    check("rel_inrdy", a_in_ready, 32'd1);
    check("rel_ovalid", a_out_valid, 32'd0);
    check("rel_oaddr", a_out_addr, 32'd0);

    // ROUNDS=1 directed vectors
    xact(1'b0, 12'h001, 16'hB000, 12'h003, 1, "r1_001", res);
    xact(1'b0, 12'h800, 16'hB000, 12'h001, 1, "r1_800", res);
    check("r1_hold_addr", a_out_addr, 32'h001);
    check("r1_idle_rdy", a_in_ready, 32'd1);
    xact(1'b0, 12'h801, 16'hFFF0, 12'h003, 1, "r1_oor_tap", res);
    xact(1'b0, 12'h801, 16'hBB55, 12'h002, 1, "r1_dup_tap", res);
    xact(1'b0, 12'h000, 16'hB321, 12'h000, 1, "r1_zero", res);

    // ROUNDS=12 hand-computed vector
    xact(1'b1, 12'h001, 16'hB000, 12'hFFE, 12, "r12_hand", res);

    // ROUNDS=12 random vector with output stall and ignored in_valid pulses
    r_addr = 12'($urandom_range(1, 4095));
    r_key  = 16'($urandom);
    exp    = model(r_addr, r_key, 12);
    b_in_addr = r_addr; b_key = r_key; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("stall_lat", lat, 32'd12);
    for (int c = 0; c < 5; c++) begin
      check("stall_ovalid", b_out_valid, 32'd1);
      check("stall_oaddr", b_out_addr, exp);
      check("stall_inrdy", b_in_ready, 32'd0);
      b_in_valid = (c % 2 == 0);
      b_in_addr  = ~r_addr;
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    check("stall_end_addr", b_out_addr, exp);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("stall_drop", b_out_valid, 32'd0);
    check("stall_idle_busy", b_busy, 32'd0);
    @(negedge clk);
    check("stall_noqueue", b_busy, 32'd0);
    check("stall_keep_addr", b_out_addr, exp);

    r_addr = 12'($urandom_range(1, 4095));
    r_key  = 16'($urandom);
    xact(1'b1, r_addr, r_key, model(r_addr, r_key, 12), 12, "r12_rand", res);

    // Reset during the 6th SHIFT cycle aborts the transaction
    b_in_addr = 12'h123; b_key = 16'hB321; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_pre", b_busy, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", b_busy, 32'd0);
    check("abort_ovalid", b_out_valid, 32'd0);
    check("abort_oaddr", b_out_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      saw = saw | b_out_valid;
    end
    check("abort_no_result", saw, 32'd0);
    xact(1'b1, 12'h001, 16'hB000, 12'hFFE, 12, "post_abort", res);

`ifdef SCRAMBLER_DESCRAMBLE_EN
    b_mode = 1'b0;
    xact(1'b1, 12'h5A3, 16'hB321, model(12'h5A3, 16'hB321, 12), 12, "ds_fwd", res);
    check("ds_fwd_kerr", b_key_err, 32'd0);
    b_mode = 1'b1;
    xact(1'b1, res, 16'hB321, 12'h5A3, 12, "ds_inv", res);
    check("ds_inv_kerr", b_key_err, 32'd0);
    b_mode = 1'b0;
    xact(1'b1, 12'h123, 16'hBB00, model(12'h123, 16'hBB00, 12), 12, "ds_bad", res);
    check("ds_bad_kerr", b_key_err, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
